// File: rtl/receive_state_machine.sv
// receive_state_machine
//
// UART receive state machine for the eUSCI_A block. Runs entirely on MCLK. BITCLK from the
// baud-rate generator is treated as data: its rising edge (seen in the MCLK domain) is a
// "bit event", and Rx is sampled only on bit events. One character is assembled per frame:
// start bit, 7/8 data bits (LSB or MSB first), optional parity, 1 or 2 stop bits. An
// evaluation cycle then computes the error/break flags. It also decides whether to load
// RxData and whether to request the receive interrupt flag.
//
// Optional build macro:
//   RX_BRK_DETECT_EN - when defined, an all-zero character is flagged as a break (rUCBRK)
//                      and only requests the IFG if wUCBRKIE is set. When undefined, rUCBRK
//                      stays 0 and all-zero characters are ordinary data.
//
// Ports:
//   MCLK      in   system clock
//   reset     in   asynchronous active-high reset (SWRST)
//   BITCLK    in   bit-rate strobe, edge-detected in MCLK domain
//   wUCPEN    in   parity enable
//   wUCPAR    in   parity select: 0 odd, 1 even
//   wUCMSB    in   1 = MSB first
//   wUC7BIT   in   1 = 7-bit data
//   wUCSPB    in   1 = two stop bits
//   wUCRXEIE  in   erroneous characters are still loaded and still raise IFG
//   wUCBRKIE  in   break characters raise IFG
//   Rx        in   serial line, idle high
//   RxIFG     in   current receive IFG (overrun detection)
//   RxBEN     out  one-cycle pulse when RxData is loaded
//   rUCPE     out  parity error
//   rUCFE     out  framing error
//   rUCOE     out  overrun error
//   rUCBRK    out  break detected
//   rSetRxIFG out  level request to set receive IFG
//   oUCRXERR  out  rUCFE | rUCPE | rUCOE
//   RxData    out  received character
//   RxBusy    out  frame in progress

module receive_state_machine (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       BITCLK,
    input  logic       wUCPEN,
    input  logic       wUCPAR,
    input  logic       wUCMSB,
    input  logic       wUC7BIT,
    input  logic       wUCSPB,
    input  logic       wUCRXEIE,
    input  logic       wUCBRKIE,
    input  logic       Rx,
    input  logic       RxIFG,
    output logic       RxBEN,
    output logic       rUCPE,
    output logic       rUCFE,
    output logic       rUCOE,
    output logic       rUCBRK,
    output logic       rSetRxIFG,
    output logic       oUCRXERR,
    output logic [7:0] RxData,
    output logic       RxBusy
);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop1,
        StStop2,
        StEval
    } state_e;

    state_e     state_q, state_d;
    logic       bitclk_q;
    logic       bit_evt;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       stop_err_q, stop_err_d;
    logic [7:0] data_q, data_d;
    logic       ben_q, ben_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       oe_q, oe_d;
    logic       brk_q, brk_d;
    logic       set_q, set_d;
    logic       busy_q, busy_d;

    logic [2:0] last_idx;
    logic [2:0] bit_idx;
    logic       brk_raw;
    logic       pe_now;
    logic       err_now;
    logic       load;

    // Single-cycle strobe on the MCLK cycle where BITCLK is first seen high.
    assign bit_evt  = BITCLK & ~bitclk_q;

    assign last_idx = wUC7BIT ? 3'd6 : 3'd7;
    // MSB-first places the first received bit at N-1 and walks down.
    assign bit_idx  = wUCMSB ? (last_idx - cnt_q) : cnt_q;

`ifdef RX_BRK_DETECT_EN
    // Unused bit 7 in 7-bit mode is cleared at start, so a plain compare covers both widths.
    assign brk_raw = (shift_q == 8'h00);
`else
    assign brk_raw = 1'b0;
`endif

    // Total XOR of data and parity must be 1 for odd (wUCPAR=0) and 0 for even (wUCPAR=1).
    assign pe_now  = wUCPEN & ((^shift_q ^ par_q) == wUCPAR);
    assign err_now = stop_err_q | pe_now | RxIFG;
    assign load    = ~err_now | wUCRXEIE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        ben_d      = 1'b0;
        pe_d       = pe_q;
        fe_d       = fe_q;
        oe_d       = oe_q;
        brk_d      = brk_q;
        set_d      = set_q;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle: begin
                if (bit_evt && !Rx) begin
                    state_d    = StData;
                    cnt_d      = 3'd0;
                    shift_d    = 8'h00;
                    par_d      = 1'b0;
                    stop_err_d = 1'b0;
                    pe_d       = 1'b0;
                    fe_d       = 1'b0;
                    oe_d       = 1'b0;
                    brk_d      = 1'b0;
                    set_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StData: begin
                if (bit_evt) begin
                    shift_d[bit_idx] = Rx;
                    if (cnt_q == last_idx) begin
                        state_d = wUCPEN ? StParity : StStop1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_evt) begin
                    par_d   = Rx;
                    state_d = StStop1;
                end
            end
            StStop1: begin
                if (bit_evt) begin
                    stop_err_d = ~Rx;
                    state_d    = wUCSPB ? StStop2 : StEval;
                end
            end
            StStop2: begin
                if (bit_evt) begin
                    stop_err_d = stop_err_q | ~Rx;
                    state_d    = StEval;
                end
            end
            StEval: begin
                fe_d   = stop_err_q;
                pe_d   = pe_now;
                oe_d   = RxIFG;
                brk_d  = brk_raw;
                set_d  = load & (~brk_raw | wUCBRKIE);
                busy_d = 1'b0;
                if (load) begin
                    data_d = shift_q;
                    ben_d  = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bitclk_q   <= 1'b0;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= 8'h00;
            ben_q      <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
            brk_q      <= 1'b0;
            set_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitclk_q   <= BITCLK;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            ben_q      <= ben_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
            brk_q      <= brk_d;
            set_q      <= set_d;
            busy_q     <= busy_d;
        end
    end

    assign RxBEN     = ben_q;
    assign rUCPE     = pe_q;
    assign rUCFE     = fe_q;
    assign rUCOE     = oe_q;
    assign rUCBRK    = brk_q;
    assign rSetRxIFG = set_q;
    assign oUCRXERR  = fe_q | pe_q | oe_q;
    assign RxData    = data_q;
    assign RxBusy    = busy_q;

endmodule

// File: tb/tb_receive_state_machine.sv
// Directed testbench for receive_state_machine. Frames are driven bit by bit with a slow
// BITCLK strobe; after each frame the flags, RxData, IFG request and the number of RxBEN
// cycles are compared against hand-computed values.

module tb_receive_state_machine;

`ifdef RX_BRK_DETECT_EN
    localparam bit BrkEn = 1'b1;
`else
    localparam bit BrkEn = 1'b0;
`endif

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       BITCLK = 1'b0;
    logic       wUCPEN = 1'b0;
    logic       wUCPAR = 1'b0;
    logic       wUCMSB = 1'b0;
    logic       wUC7BIT = 1'b0;
    logic       wUCSPB = 1'b0;
    logic       wUCRXEIE = 1'b0;
    logic       wUCBRKIE = 1'b0;
    logic       Rx = 1'b1;
    logic       RxIFG = 1'b0;
    logic       RxBEN;
    logic       rUCPE;
    logic       rUCFE;
    logic       rUCOE;
    logic       rUCBRK;
    logic       rSetRxIFG;
    logic       oUCRXERR;
    logic [7:0] RxData;
    logic       RxBusy;

    int n_checks = 0;
    int n_errors = 0;
    int ben_cnt = 0;
    int ben_base = 0;

    receive_state_machine dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .BITCLK    (BITCLK),
        .wUCPEN    (wUCPEN),
        .wUCPAR    (wUCPAR),
        .wUCMSB    (wUCMSB),
        .wUC7BIT   (wUC7BIT),
        .wUCSPB    (wUCSPB),
        .wUCRXEIE  (wUCRXEIE),
        .wUCBRKIE  (wUCBRKIE),
        .Rx        (Rx),
        .RxIFG     (RxIFG),
        .RxBEN     (RxBEN),
        .rUCPE     (rUCPE),
        .rUCFE     (rUCFE),
        .rUCOE     (rUCOE),
        .rUCBRK    (rUCBRK),
        .rSetRxIFG (rSetRxIFG),
        .oUCRXERR  (oUCRXERR),
        .RxData    (RxData),
        .RxBusy    (RxBusy)
    );

    always #5 MCLK = ~MCLK;

    // Counts MCLK cycles with RxBEN high, so a stuck pulse shows up as a count above one.
    always @(posedge MCLK) begin
        if (RxBEN === 1'b1) ben_cnt <= ben_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_pulse(input logic val);
        @(negedge MCLK);
        Rx     = val;
        BITCLK = 1'b1;
        repeat (2) @(negedge MCLK);
        BITCLK = 1'b0;
        repeat (3) @(negedge MCLK);
    endtask

    task automatic set_cfg(input logic pen, input logic par, input logic msb, input logic b7,
                           input logic spb, input logic eie, input logic brkie);
        wUCPEN   = pen;
        wUCPAR   = par;
        wUCMSB   = msb;
        wUC7BIT  = b7;
        wUCSPB   = spb;
        wUCRXEIE = eie;
        wUCBRKIE = brkie;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] data, input logic par_bit,
                              input logic stop1, input logic stop2);
        int nbits;
        nbits    = wUC7BIT ? 7 : 8;
        ben_base = ben_cnt;
        bit_pulse(1'b0);
        check_val({tag, ".busy"}, 32'(RxBusy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            bit_pulse(wUCMSB ? data[nbits - 1 - i] : data[i]);
        end
        if (wUCPEN) bit_pulse(par_bit);
        bit_pulse(stop1);
        if (wUCSPB) bit_pulse(stop2);
        @(negedge MCLK);
        Rx = 1'b1;
    endtask

    task automatic check_result(input string tag, input logic [7:0] exp_data,
                                input logic pe, input logic fe, input logic oe,
                                input logic brk, input logic set, input int ben);
        check_val({tag, ".data"}, 32'(RxData), 32'(exp_data));
        check_val({tag, ".pe"}, 32'(rUCPE), 32'(pe));
        check_val({tag, ".fe"}, 32'(rUCFE), 32'(fe));
        check_val({tag, ".oe"}, 32'(rUCOE), 32'(oe));
        check_val({tag, ".brk"}, 32'(rUCBRK), 32'(brk));
        check_val({tag, ".err"}, 32'(oUCRXERR), 32'(pe | fe | oe));
        check_val({tag, ".setifg"}, 32'(rSetRxIFG), 32'(set));
        check_val({tag, ".ben"}, 32'(ben_cnt - ben_base), 32'(ben));
        check_val({tag, ".idle"}, 32'(RxBusy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".outs"},
                  32'({RxBEN, rUCPE, rUCFE, rUCOE, rUCBRK, rSetRxIFG, oUCRXERR, RxBusy}), 32'd0);
        check_val({tag, ".data"}, 32'(RxData), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge MCLK);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge MCLK);
        check_all_zero("post_reset");

        // 8N1, LSB first, EIE=0, BRKIE=0
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b1);
        check_result("a5", 8'hA5, 0, 0, 0, 0, 1, 1);

        send_frame("fe_3e", 8'h3E, 1'b0, 1'b0, 1'b1);
        check_result("fe_3e", 8'hA5, 0, 1, 0, 0, 0, 0);

        RxIFG = 1'b1;
        send_frame("oe_6c", 8'h6C, 1'b0, 1'b1, 1'b1);
        check_result("oe_6c", 8'hA5, 0, 0, 1, 0, 0, 0);
        RxIFG = 1'b0;

        // 8-bit, odd parity, 2 stop, EIE=1, BRKIE=1
        set_cfg(1, 0, 0, 0, 1, 1, 1);
        send_frame("p55", 8'h55, 1'b1, 1'b1, 1'b1);
        check_result("p55", 8'h55, 0, 0, 0, 0, 1, 1);

        send_frame("pe_a4", 8'hA4, 1'b1, 1'b1, 1'b1);
        check_result("pe_a4", 8'hA4, 1, 0, 0, 0, 1, 1);

        send_frame("fe_brk", 8'h00, 1'b1, 1'b1, 1'b0);
        check_result("fe_brk", 8'h00, 0, 1, 0, BrkEn, 1, 1);

        // MSB first, even parity, 1 stop, EIE=0, BRKIE=1
        set_cfg(1, 1, 1, 0, 0, 0, 1);
        send_frame("pe_brk", 8'h00, 1'b1, 1'b1, 1'b1);
        check_result("pe_brk", 8'h00, 1, 0, 0, BrkEn, 0, 0);

        send_frame("msb_1d", 8'h1D, 1'b0, 1'b1, 1'b1);
        check_result("msb_1d", 8'h1D, 0, 0, 0, 0, 1, 1);

        // 7-bit LSB, no parity, 1 stop, BRKIE=1
        set_cfg(0, 0, 0, 1, 0, 0, 1);
        send_frame("brk7", 8'h00, 1'b0, 1'b1, 1'b1);
        check_result("brk7", 8'h00, 0, 0, 0, BrkEn, 1, 1);

        // 8-bit break with BRKIE=0: loaded, IFG only when break detection is absent
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        send_frame("brk8", 8'h00, 1'b0, 1'b1, 1'b1);
        check_result("brk8", 8'h00, 0, 0, 0, BrkEn, !BrkEn, 1);

        // 7-bit MSB, odd parity, 2 stop, EIE=1
        set_cfg(1, 0, 1, 1, 1, 1, 0);
        send_frame("fe7_12", 8'h12, 1'b1, 1'b1, 1'b0);
        check_result("fe7_12", 8'h12, 0, 1, 0, 0, 1, 1);

        // Reset in the middle of a frame
        bit_pulse(1'b0);
        bit_pulse(1'b1);
        bit_pulse(1'b0);
        check_val("mid.busy", 32'(RxBusy), 32'd1);
        @(negedge MCLK);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge MCLK);
        reset = 1'b0;
        Rx    = 1'b1;
        repeat (2) @(negedge MCLK);

        // Recovery: 8N1 LSB, asymmetric pattern
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        send_frame("rec_4b", 8'h4B, 1'b0, 1'b1, 1'b1);
        check_result("rec_4b", 8'h4B, 0, 0, 0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
